// File: rtl/sdram_read.sv
// Purpose: SDRAM read master; arbitrated ACT/READ(BL4)/PRE sessions that stream low data bytes into a read FIFO.
// Latency: READ on the bus in cycle c gives FIFO strobes in cycles c+CAS_LAT+1 .. c+CAS_LAT+4.
// Backpressure: none from the FIFO; yields the bus at a burst boundary on ref_req and waits for rd_en.
module sdram_read #(
    parameter int CAS_LAT   = 3,
    parameter int NUM_BURST = 128
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        rd_trig,
    output logic        rd_req,
    input  logic        rd_en,
    input  logic        ref_req,
    output logic        flag_rd_end,
    output logic [3:0]  rd_cmd,
    output logic [11:0] rd_addr,
    output logic [1:0]  bank_addr,
    input  logic [15:0] rd_data,
    output logic        rfifo_wr_en,
    output logic [7:0]  rfifo_wr_data
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam int         PIPE_W   = CAS_LAT + 3;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_RD, S_PRE} state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic [8:0]          burst_left;
    logic [11:0]         row_ptr;
    logic [6:0]          col_ptr;
    logic                last_col;
    logic                ref_lat;
    logic                rd_exit;
    logic                issue_rd;
    logic [PIPE_W-1:0]   rd_pipe;
    logic                sample;
    logic                unused_hi;

    assign bank_addr = 2'b00;
    assign rd_req    = (state == S_REQ);
    assign sample    = |rd_pipe[CAS_LAT+2:CAS_LAT-1];
    assign unused_hi = ^rd_data[15:8];

    // Decide whether the burst boundary ends the row session and whether a READ goes out this edge
    always_comb begin
        rd_exit  = (burst_left == 9'd0) || ref_req || last_col;
        issue_rd = 1'b0;
        if (cnt == 2'd3) begin
            if (state == S_ACT)
                issue_rd = 1'b1;
            else if (state == S_RD && !rd_exit)
                issue_rd = 1'b1;
        end
    end

    // Address pointers and burst budget; pointers survive sessions so reads resume where they left off
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            burst_left <= '0;
            row_ptr    <= '0;
            col_ptr    <= '0;
            last_col   <= 1'b0;
        end else if (state == S_IDLE && rd_trig) begin
            burst_left <= 9'(NUM_BURST);
        end else if (issue_rd) begin
            burst_left <= burst_left - 9'd1;
            col_ptr    <= col_ptr + 7'd1;
            last_col   <= (col_ptr == 7'd127);
            if (col_ptr == 7'd127)
                row_ptr <= row_ptr + 12'd1;
        end
    end

    // Session FSM with registered command/address so both change together on the clock edge
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ref_lat     <= 1'b0;
            flag_rd_end <= 1'b0;
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
        end else begin
            flag_rd_end <= 1'b0;
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
            case (state)
                S_IDLE: begin
                    if (rd_trig)
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (rd_en) begin
                        state   <= S_ACT;
                        cnt     <= '0;
                        rd_cmd  <= CMD_ACT;
                        rd_addr <= row_ptr;
                    end
                end
                S_ACT: begin
                    if (cnt == 2'd3) begin
                        state   <= S_RD;
                        cnt     <= '0;
                        rd_cmd  <= CMD_READ;
                        rd_addr <= {3'b000, col_ptr, 2'b00};
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_RD: begin
                    if (cnt == 2'd3) begin
                        cnt <= '0;
                        if (rd_exit) begin
                            state   <= S_PRE;
                            ref_lat <= ref_req;
                            rd_cmd  <= CMD_PRE;
                            rd_addr <= 12'h400;
                        end else begin
                            rd_cmd  <= CMD_READ;
                            rd_addr <= {3'b000, col_ptr, 2'b00};
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_PRE: begin
                    if (cnt == 2'd3) begin
                        cnt <= '0;
                        if (burst_left == 9'd0) begin
                            state       <= S_IDLE;
                            flag_rd_end <= 1'b1;
                        end else if (ref_lat) begin
                            state       <= S_REQ;
                            flag_rd_end <= 1'b1;
                        end else begin
                            state   <= S_ACT;
                            rd_cmd  <= CMD_ACT;
                            rd_addr <= row_ptr;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture pipeline: tracks READs on the bus and samples DQ across the CAS-delayed 4-beat window
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            rd_pipe       <= '0;
            rfifo_wr_en   <= 1'b0;
            rfifo_wr_data <= '0;
        end else begin
            rd_pipe     <= {rd_pipe[PIPE_W-2:0], (rd_cmd == CMD_READ)};
            rfifo_wr_en <= sample;
            if (sample)
                rfifo_wr_data <= rd_data[7:0];
        end
    end

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench: two instances (8 bursts / CAS 3 and 129 bursts / CAS 2) driven through
// normal, refresh-yield, final-burst refresh, mid-session reset and row-crossing sessions.
module tb_sdram_read;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, PRE = 4'b0010;

    logic        sclk = 1'b0;
    logic        reset;
    logic [15:0] rd_data;
    logic        t0, e0, r0, q0, f0, w0;
    logic [3:0]  c0;
    logic [11:0] a0;
    logic [1:0]  b0;
    logic [7:0]  d0;
    logic        t1, e1, r1, q1, f1, w1;
    logic [3:0]  c1;
    logic [11:0] a1;
    logic [1:0]  b1;
    logic [7:0]  d1;

    int total = 0;
    int bad   = 0;
    int s0 = 0, fl0 = 0, rdc0 = 0, rq0 = 0;
    int s1 = 0, fl1 = 0, rdc1 = 0;

    always #5 sclk = ~sclk;

    sdram_read #(.CAS_LAT(3), .NUM_BURST(8)) u0 (
        .sclk(sclk), .reset(reset), .rd_trig(t0), .rd_req(q0), .rd_en(e0), .ref_req(r0),
        .flag_rd_end(f0), .rd_cmd(c0), .rd_addr(a0), .bank_addr(b0), .rd_data(rd_data),
        .rfifo_wr_en(w0), .rfifo_wr_data(d0));

    sdram_read #(.CAS_LAT(2), .NUM_BURST(129)) u1 (
        .sclk(sclk), .reset(reset), .rd_trig(t1), .rd_req(q1), .rd_en(e1), .ref_req(r1),
        .flag_rd_end(f1), .rd_cmd(c1), .rd_addr(a1), .bank_addr(b1), .rd_data(rd_data),
        .rfifo_wr_en(w1), .rfifo_wr_data(d1));

    // Event counters sampled mid-cycle
    always @(negedge sclk) begin
        if (w0) s0 <= s0 + 1;
        if (f0) fl0 <= fl0 + 1;
        if (c0 == RD) rdc0 <= rdc0 + 1;
        if (q0) rq0 <= rq0 + 1;
        if (w1) s1 <= s1 + 1;
        if (f1) fl1 <= fl1 + 1;
        if (c1 == RD) rdc1 <= rdc1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
        rd_data = rd_data + 16'h0103;
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait0(input logic [3:0] cmd, input string tag);
        int n = 0;
        while (c0 !== cmd && n < 3000) begin step(); n++; end
        chk(tag, c0, cmd);
    endtask

    task automatic wait1(input logic [3:0] cmd, input string tag);
        int n = 0;
        while (c1 !== cmd && n < 3000) begin step(); n++; end
        chk(tag, c1, cmd);
    endtask

    // Trigger u0, grant two cycles later; returns in the ACT cycle
    task automatic start0();
        t0 = 1'b1; step(); t0 = 1'b0;
        chk("u0 rd_req after trig", q0, 1);
        stepn(2);
        chk("u0 hold in REQ", q0, 1);
        e0 = 1'b1; step(); e0 = 1'b0;
        chk("u0 ACT cmd", c0, ACT);
    endtask

    initial begin
        int bs, bf, br, bq, n;
        logic [7:0] expd [4];
        reset = 1'b0; rd_data = 16'h1234;
        t0 = 0; e0 = 0; r0 = 0; t1 = 0; e1 = 0; r1 = 0;
        stepn(3);
        chk("reset cmd", c0, NOP);
        chk("reset addr", a0, 0);
        chk("reset rd_req", q0, 0);
        chk("reset flag", f0, 0);
        chk("reset wr_en", w0, 0);
        chk("reset wr_data", d0, 0);
        chk("bank addr", b0, 0);
        chk("reset cmd u1", c1, NOP);
        reset = 1'b1;
        stepn(2);

        // Session A: plain 8-burst session from row 0 col 0
        bs = s0; bf = fl0; br = rdc0;
        start0();
        chk("A ACT row", a0, 0);
        chk("A rd_req drops", q0, 0);
        stepn(3);
        chk("A tRCD nop", c0, NOP);
        step();
        chk("A first READ", c0, RD);
        chk("A col0 addr", a0, 0);
        stepn(3);
        chk("A strobe idle before CAS", w0, 0);
        step();
        chk("A second READ addr", a0, 4);
        chk("A first strobe at c+4", w0, 1);
        wait0(PRE, "A reach PRE");
        chk("A PRE addr", a0, 12'h400);
        stepn(3);
        chk("A no flag during PRE", f0, 0);
        step();
        chk("A flag", f0, 1);
        chk("A idle no req", q0, 0);
        step();
        chk("A flag one cycle", f0, 0);
        stepn(6);
        chk("A strobes", s0 - bs, 32);
        chk("A flags", fl0 - bf, 1);
        chk("A reads", rdc0 - br, 8);

        // Session B: refresh raised mid-burst of third burst, session resumes at col 8
        bs = s0; bf = fl0;
        start0();
        wait0(RD, "B first READ");
        chk("B resume col 8", a0, 32);
        stepn(4);
        chk("B second READ", a0, 36);
        stepn(4);
        chk("B third READ", a0, 40);
        step(); r0 = 1'b1;
        stepn(2);
        chk("B burst not truncated", c0, NOP);
        step();
        chk("B PRE on ref", c0, PRE);
        r0 = 1'b0;
        stepn(4);
        chk("B flag on yield", f0, 1);
        chk("B back to REQ", q0, 1);
        e0 = 1'b1; step(); e0 = 1'b0;
        chk("B re-ACT cmd", c0, ACT);
        chk("B re-ACT row", a0, 0);
        stepn(4);
        chk("B resume READ", c0, RD);
        chk("B resume col 11", a0, 44);
        wait0(PRE, "B final PRE");
        stepn(4);
        chk("B end flag", f0, 1);
        chk("B end idle", q0, 0);
        stepn(6);
        chk("B strobes", s0 - bs, 32);
        chk("B flags", fl0 - bf, 2);

        // Session C: refresh in cycle 3 of final burst still ends the session
        bf = fl0;
        start0();
        n = 0;
        for (int k = 0; k < 200 && n < 8; k++) begin
            step();
            if (c0 == RD) n++;
        end
        chk("C found 8 READs", n, 8);
        stepn(3); r0 = 1'b1;
        step();
        chk("C PRE", c0, PRE);
        r0 = 1'b0;
        stepn(4);
        chk("C flag", f0, 1);
        chk("C idle not REQ", q0, 0);
        bq = rq0;
        stepn(20);
        chk("C no further rd_req", rq0 - bq, 0);
        chk("C single flag", fl0 - bf, 1);

        // Session D: reset mid-RD
        start0();
        wait0(RD, "D READ");
        stepn(2);
        reset = 1'b0; #1;
        chk("D reset cmd", c0, NOP);
        chk("D reset addr", a0, 0);
        chk("D reset req", q0, 0);
        chk("D reset wr_en", w0, 0);
        chk("D reset wr_data", d0, 0);
        bs = s0;
        stepn(3);
        reset = 1'b1;
        stepn(10);
        chk("D no strobes after reset", s0 - bs, 0);
        start0();
        chk("D row 0", a0, 0);
        stepn(4);
        chk("D READ after reset", c0, RD);
        chk("D col 0", a0, 0);
        wait0(PRE, "D PRE");
        stepn(10);

        // Session E on u1: CAS 2 data timing and row crossing
        bs = s1; bf = fl1; br = rdc1;
        t1 = 1'b1; step(); t1 = 1'b0;
        chk("E rd_req", q1, 1);
        e1 = 1'b1; step(); e1 = 1'b0;
        chk("E ACT", c1, ACT);
        chk("E ACT row 0", a1, 0);
        stepn(4);
        chk("E first READ", c1, RD);
        chk("E col 0", a1, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k >= 2 && k <= 5) expd[k-2] = rd_data[7:0];
            if (k == 2) chk("E no strobe at c+2", w1, 0);
            if (k >= 3) begin
                chk("E strobe c+3..c+6", w1, 1);
                chk("E data", d1, expd[k-3]);
            end
        end
        wait1(PRE, "E row-end PRE");
        chk("E PRE addr", a1, 12'h400);
        chk("E 128 reads in row", rdc1 - br, 128);
        stepn(4);
        chk("E re-ACT", c1, ACT);
        chk("E row 1", a1, 1);
        chk("E no flag on row change", fl1 - bf, 0);
        chk("E keeps bus", q1, 0);
        stepn(4);
        chk("E READ row 1", c1, RD);
        chk("E col wrapped", a1, 0);
        wait1(PRE, "E final PRE");
        stepn(4);
        chk("E end flag", f1, 1);
        stepn(6);
        chk("E strobes", s1 - bs, 516);
        chk("E flags", fl1 - bf, 1);
        chk("E reads", rdc1 - br, 129);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_read.md
SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 Parameter CAS_LAT, default 3, SDRAM CAS latency in sclk cycles (legal 2 or 3).
REQ-002 Parameter NUM_BURST, default 128, BL4 bursts per read session (legal 1..256).
REQ-003 sclk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rd_trig  in  1  start a read session.
REQ-006 rd_req  out  1  bus request to arbiter.
REQ-007 rd_en  in  1  arbiter grant.
REQ-008 ref_req  in  1  refresh pending; yield bus at next burst boundary.
REQ-009 flag_rd_end  out  1  one-cycle pulse: bus released to arbiter.
REQ-010 rd_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}: NOP 0111, ACT 0011, READ 0101, PRE 0010.
REQ-011 rd_addr  out  12  SDRAM address bus.
REQ-012 bank_addr  out  2  constant 2'b00.
REQ-013 rd_data  in  16  SDRAM DQ input.
REQ-014 rfifo_wr_en  out  1  read-FIFO write strobe.
REQ-015 rfifo_wr_data  out  8  read-FIFO write data.

Function
REQ-016 States: IDLE, REQ, ACT, RD, PRE; rd_req = (state==REQ).
REQ-017 IDLE: rd_trig=1 -> REQ, load burst_left=NUM_BURST; rd_trig outside IDLE ignored.
REQ-018 REQ: rd_en=1 -> ACT; else hold (ref_req has no effect in REQ).
REQ-019 ACT: 4 cycles; cycle 0 ACT with rd_addr=row_ptr, cycles 1-3 NOP, addr 0; then RD.
REQ-020 RD: bursts of 4 cycles (burst_cnt 0..3); cycle 0 READ, rd_addr={3'b000,col_ptr,2'b00}; cycles 1-3 NOP, addr 0.
REQ-021 Each READ: burst_left-1; col_ptr (7 bits) +1; col_ptr 127->0 increments row_ptr (12 bits); row 4095->0.
REQ-022 At burst_cnt==3 exit to PRE if burst_left==0, ref_req==1, or burst just issued had col_ptr==127; else next burst.
REQ-023 ref_req sampled only at burst_cnt==3; earlier assertion does not truncate a burst; at least one burst per ACT.
REQ-024 PRE: 4 cycles; cycle 0 PRE with rd_addr=12'h400 (A10 all-bank), cycles 1-3 NOP, addr 0.
REQ-025 PRE exit priority: burst_left==0 -> IDLE; else ref_req latched at exit decision -> REQ; else (row end) -> ACT.
REQ-026 flag_rd_end = 1 exactly in the first cycle after PRE->IDLE or PRE->REQ; never on PRE->ACT.
REQ-027 rd_cmd, rd_addr registered and mutually aligned; both change only on sclk edges.
REQ-028 Capture: READ on bus in cycle c -> rd_data[7:0] sampled at ends of cycles c+CAS_LAT..c+CAS_LAT+3.
REQ-029 Each sample drives rfifo_wr_data with rfifo_wr_en=1 in the following cycle; back-to-back bursts give continuous strobes.
REQ-030 Capture pipeline runs independently of state; in-flight data completes after leaving RD.
REQ-031 Exactly 4*NUM_BURST rfifo_wr_en cycles per session; no FIFO backpressure.
REQ-032 row_ptr/col_ptr persist across sessions; next session resumes at next column.

Reset
REQ-033 reset low, any state: state=IDLE, rd_cmd=0111, rd_addr=0, rd_req=0, flag_rd_end=0, rfifo_wr_en=0, rfifo_wr_data=0, row_ptr=0, col_ptr=0, counters 0, capture pipeline cleared.
REQ-034 Reset mid-session discards in-flight read data; no rfifo_wr_en after reset assertion.

Verification
REQ-035 NUM_BURST=2, CAS_LAT=3, pulse rd_trig, rd_en 2 cycles later -> ACT addr 0; READ addr 0 three cycles later; READ addr 4; PRE addr 0x400; 8 strobes, first 4 cycles after first READ; one flag_rd_end; IDLE.
REQ-036 NUM_BURST=129 from reset -> 128 READs cols 0..508 row 0; PRE; ACT addr 1; READ addr 0; 516 strobes; flag_rd_end only at session end.
REQ-037 NUM_BURST=8, ref_req high during burst 2 cycle 1 -> burst completes; PRE; flag_rd_end; REQ; after rd_en, ACT row 0, READ col 12.
REQ-038 ref_req high in cycle 3 of final burst -> PRE then IDLE, single flag_rd_end, no further rd_req.
REQ-039 reset low during RD -> outputs at REQ-033 values same cycle; no strobes after; new trig starts at row 0, col 0.
REQ-040 CAS_LAT=2, NUM_BURST=1 -> strobes in cycles c+3..c+6 after READ cycle c, data = rd_data[7:0] sampled c+2..c+5.
